pma_region_unit: RTL
====================

# pma_region_unit

Runtime-programmable physical-memory-attribute (PMA) checker replacing fixed execute/cached/non-idempotent region tables with NrRules writable rules. Sits between the address-translation output and the fetch/LSU paths: each physical address is looked up in a 2-stage, backpressured pipeline that returns hit, rule index and execute/cacheable/non-idempotent attributes. A small config port lets M-mode firmware (via CSR glue) program, read back and lock rules.

## Interface
- NrRules, 8: number of rules, 1..16.
- AddrWidth, 64: physical address / config data width.
- TagWidth, 4: opaque lookup tag carried to the result.
- DefaultAttr, 3'b100: {NI,C,X} returned on miss (non-idempotent, uncached, no-exec).
- IdxW, $clog2(NrRules) with minimum 1: derived, not overridable.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  drop all in-flight lookups.
- cfg_req_i  in  1  config access this cycle.
- cfg_we_i  in  1  1 = write, 0 = read.
- cfg_idx_i  in  IdxW  rule index.
- cfg_sel_i  in  2  0 = base, 1 = length, 2 = attr, 3 = reserved.
- cfg_wdata_i  in  AddrWidth  write data.
- cfg_rvalid_o  out  1  read data / write ack valid, 1 cycle after cfg_req_i.
- cfg_rdata_o  out  AddrWidth  read data.
- cfg_err_o  out  1  access error, same cycle as cfg_rvalid_o.
- lk_valid_i  in  1  lookup request.
- lk_ready_o  out  1  lookup accepted when valid & ready.
- lk_addr_i  in  AddrWidth  physical address.
- lk_tag_i  in  TagWidth  tag.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  consumer ready.
- res_tag_o  out  TagWidth  tag of the lookup.
- res_hit_o  out  1  some rule matched.
- res_idx_o  out  IdxW  matching rule (0 on miss).
- res_exec_o, res_cached_o, res_nonidem_o  out  1 each  attributes.

## Operation
- Rule state: base, length (AddrWidth each), attr {L(bit7), NI(bit2), C(bit1), X(bit0)}; other attr bits read 0.
- Match: length != 0 and base <= addr and addr < base+length, sum computed in AddrWidth+1 bits (no wrap; region may end exactly at 2^AddrWidth).
- Priority: lowest matching index wins; miss returns DefaultAttr, hit=0, idx=0.
- Stage 1 (accept edge): match vector compared against current rule state and registered with tag; a config write in the same cycle is not seen by that lookup.
- Stage 2: priority encode + attribute mux registered into result outputs.
- Config write: applied at the edge of the request; ignored with cfg_err_o=1 if rule L=1, cfg_idx_i >= NrRules, or cfg_sel_i=3. Setting L is permanent until reset; a locked rule's base/length/attr are all read-only.
- Config read: cfg_rdata_o = selected field; 0 with cfg_err_o=1 on bad index/sel.
- Every cfg_req_i produces exactly one cfg_rvalid_o pulse next cycle.

## Timing
- Reset: all base/length/attr/lock = 0 (no rules active), stage valids 0, all outputs 0.
- Latency: lookup accepted in cycle n -> res_valid_o in cycle n+2; throughput 1/cycle.
- lk_ready_o = !flush_i & (!s1_valid | !res_valid_o | res_ready_i); stage 1 advances only if stage 2 empty or consumed.
- Stalled result holds all res_* stable while res_valid_o & !res_ready_i.
- flush_i: both stage valids cleared at the next edge; no lookup accepted that cycle; config state untouched.
- Reset mid-operation: in-flight lookups lost, rules cleared immediately (asynchronous).
- Config port never stalls; config and lookup are independent.

## Test plan
- Reset, lookup 0x8000_0000 -> cycle n+2 res_hit_o=0, {NI,C,X}=3'b100, idx=0.
- Program rule1 base 0x8000_0000 len 0x4000_0000 attr 0x03; lookup 0xBFFF_FFFF -> hit, idx=1, X=1 C=1 NI=0; lookup 0xC000_0000 -> miss.
- Rule0 base 0x8000_0000 len 0x1000 attr 0x04 overlaps rule1; lookup 0x8000_0800 -> idx=0, NI=1; 0x8000_1000 -> idx=1.
- Lock rule1 (attr 0x83), write len 0 -> cfg_err_o=1, readback len still 0x4000_0000; read idx NrRules -> rdata 0, err=1.
- Rule base 0xFFFF_FFFF_FFFF_F000 len 0x1000; lookup 0xFFFF_FFFF_FFFF_FFFF -> hit (no overflow).
- Back-to-back 4 lookups with res_ready_i low 3 cycles -> lk_ready_o drops after 2 accepted, results in order, tags intact; flush_i mid-stream -> res_valid_o 0 next cycle.

Source files
------------

// File: rtl/pma_region_unit.sv
// pma_region_unit
//   Runtime-programmable physical-memory-attribute checker. NrRules writable
//   rules (base, length, attr {L,NI,C,X}) are matched against each physical
//   address in a 2-stage backpressured pipeline. The lowest matching rule
//   index wins. A miss returns DefaultAttr.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              drop all in-flight lookups
//   cfg_req_i/we_i/idx_i/sel_i/wdata_i
//                        config access (sel 0=base, 1=length, 2=attr)
//   cfg_rvalid_o/rdata_o/err_o
//                        one-cycle response to every cfg_req_i
//   lk_valid_i/ready_o/addr_i/tag_i
//                        lookup request handshake
//   res_valid_o/ready_i/tag_o/hit_o/idx_o/exec_o/cached_o/nonidem_o
//                        lookup result handshake
module pma_region_unit #(
    parameter int unsigned NrRules     = 8,
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned TagWidth    = 4,
    parameter logic [2:0]  DefaultAttr = 3'b100,
    localparam int unsigned IdxW       = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [IdxW-1:0]      cfg_idx_i,
    input  logic [1:0]           cfg_sel_i,
    input  logic [AddrWidth-1:0] cfg_wdata_i,
    output logic                 cfg_rvalid_o,
    output logic [AddrWidth-1:0] cfg_rdata_o,
    output logic                 cfg_err_o,
    input  logic                 lk_valid_i,
    output logic                 lk_ready_o,
    input  logic [AddrWidth-1:0] lk_addr_i,
    input  logic [TagWidth-1:0]  lk_tag_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [TagWidth-1:0]  res_tag_o,
    output logic                 res_hit_o,
    output logic [IdxW-1:0]      res_idx_o,
    output logic                 res_exec_o,
    output logic                 res_cached_o,
    output logic                 res_nonidem_o
);

    // Rule state. attr_q packs {L, NI, C, X}; L is bit 7 of the visible field.
    logic [AddrWidth-1:0] base_q [NrRules];
    logic [AddrWidth-1:0] len_q  [NrRules];
    logic [3:0]           attr_q [NrRules];

    // ------------------------------------------------------------------
    // Config port
    // ------------------------------------------------------------------
    logic                 idx_ok;
    logic [IdxW-1:0]      idx_safe;
    logic                 cfg_bad;
    logic                 wr_err;
    logic                 wr_en;
    logic [AddrWidth-1:0] field;
    logic [AddrWidth-1:0] rdata_d;
    logic                 err_d;

    assign idx_ok   = 32'(cfg_idx_i) < NrRules;
    // Out-of-range indices are redirected to rule 0 so the array is never
    // addressed past its end; the result is masked by cfg_bad anyway.
    assign idx_safe = idx_ok ? cfg_idx_i : '0;
    assign cfg_bad  = !idx_ok || (cfg_sel_i == 2'd3);
    assign wr_err   = cfg_bad || attr_q[idx_safe][3];
    assign wr_en    = cfg_req_i && cfg_we_i && !wr_err;

    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        field = '0;
        unique case (cfg_sel_i)
            2'd0:    field = base_q[idx_safe];
            2'd1:    field = len_q[idx_safe];
            2'd2:    field = AddrWidth'({attr_q[idx_safe][3], 4'b0000, attr_q[idx_safe][2:0]});
            default: field = '0;
        endcase
    end

    assign rdata_d = (cfg_req_i && !cfg_we_i && !cfg_bad) ? field : '0;
    assign err_d   = cfg_req_i && (cfg_we_i ? wr_err : cfg_bad);

    // NOTE: the rule table is reset explicitly because reset must leave no
    // rule active and no lock set; it is a register file, not a RAM macro.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NrRules; i++) begin
                base_q[i] <= '0;
                len_q[i]  <= '0;
                attr_q[i] <= '0;
            end
        end else if (wr_en) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            unique case (cfg_sel_i)
                2'd0:    base_q[idx_safe] <= cfg_wdata_i;
                2'd1:    len_q[idx_safe]  <= cfg_wdata_i;
                default: attr_q[idx_safe] <= {cfg_wdata_i[7], cfg_wdata_i[2:0]};
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_rvalid_o <= 1'b0;
            cfg_rdata_o  <= '0;
            cfg_err_o    <= 1'b0;
        end else begin
            cfg_rvalid_o <= cfg_req_i;
            cfg_rdata_o  <= rdata_d;
            cfg_err_o    <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Lookup pipeline
    // ------------------------------------------------------------------
    logic                s1_valid;
    logic [TagWidth-1:0] s1_tag;
    logic [NrRules-1:0]  s1_match;
    logic [NrRules-1:0]  match_d;
    logic                s2_adv;
    logic                hit_d;
    logic [IdxW-1:0]     idx_d;
    logic [2:0]          attr_d;

    // Region end is formed one bit wider so a region ending exactly at
    // 2^AddrWidth does not wrap to zero.
    always_comb begin
        match_d = '0;
        for (int i = 0; i < NrRules; i++) begin
            logic [AddrWidth:0] lim;
            lim        = {1'b0, base_q[i]} + {1'b0, len_q[i]};
            match_d[i] = (len_q[i] != '0) && (base_q[i] <= lk_addr_i) &&
                         ({1'b0, lk_addr_i} < lim);
        end
    end

    assign s2_adv     = !res_valid_o || res_ready_i;
    assign lk_ready_o = !flush_i && (!s1_valid || s2_adv);

    // Descending scan so the lowest matching index is the last one written.
    always_comb begin
        hit_d = 1'b0;
        idx_d = '0;
        for (int i = NrRules - 1; i >= 0; i--) begin
            if (s1_match[i]) begin
                hit_d = 1'b1;
                idx_d = IdxW'(i);
            end
        end
        attr_d = hit_d ? attr_q[idx_d][2:0] : DefaultAttr;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_tag   <= '0;
            s1_match <= '0;
        end else if (flush_i) begin
            s1_valid <= 1'b0;
        end else if (lk_ready_o) begin
            s1_valid <= lk_valid_i;
            if (lk_valid_i) begin
                s1_tag   <= lk_tag_i;
                s1_match <= match_d;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_valid_o   <= 1'b0;
            res_tag_o     <= '0;
            res_hit_o     <= 1'b0;
            res_idx_o     <= '0;
            res_exec_o    <= 1'b0;
            res_cached_o  <= 1'b0;
            res_nonidem_o <= 1'b0;
        end else if (flush_i) begin
            res_valid_o <= 1'b0;
        end else if (s2_adv) begin
            res_valid_o <= s1_valid;
            // Payload only moves with a valid entry, so a stalled or drained
            // result keeps its fields stable.
            if (s1_valid) begin
                res_tag_o     <= s1_tag;
                res_hit_o     <= hit_d;
                res_idx_o     <= idx_d;
                res_nonidem_o <= attr_d[2];
                res_cached_o  <= attr_d[1];
                res_exec_o    <= attr_d[0];
            end
        end
    end

endmodule
